// File: rtl/rrf_free_list.sv
// rtl/rrf_free_list.sv - circular free-tag list for the 32-entry rename register file.
// Optional synchronous list restore via `define FREELIST_FLUSH_EN (adds flush input).
module rrf_free_list #(
  parameter int TAG_W    = 5,
  parameter int NUM_TAGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req_1,
  input  logic             alloc_req_2,
  output logic [TAG_W-1:0] alloc_tag_1,
  output logic [TAG_W-1:0] alloc_tag_2,
  output logic             alloc_valid_1,
  output logic             alloc_valid_2,
  output logic             alloc_stall,
  input  logic [TAG_W-1:0] free_tag,
  input  logic             free_valid,
`ifdef FREELIST_FLUSH_EN
  input  logic             flush,
`endif
  output logic [TAG_W:0]   free_count,
  output logic             err_overflow
);

  localparam int DEPTH = NUM_TAGS - 1;
  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0] fifo [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;

  logic [1:0]       n_req;
  logic [1:0]       n_grant;
  logic             stall_raw;
  logic             flush_on;
  logic             push;
  logic             overflow_hit;
  logic [TAG_W-1:0] head_plus1;

  // Depth is not a power of two, so pointers wrap explicitly at DEPTH.
  function automatic logic [TAG_W-1:0] wrap_add(input logic [TAG_W-1:0] p, input logic [1:0] n);
    logic [TAG_W:0] s;
    s = {1'b0, p} + (TAG_W+1)'(n);
    if (s >= FULL) s = s - FULL;
    return s[TAG_W-1:0];
  endfunction

  always_comb begin
`ifdef FREELIST_FLUSH_EN
    flush_on = flush;
`else
    flush_on = 1'b0;
`endif
    n_req         = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
    stall_raw     = (TAG_W+1)'(n_req) > count;
    alloc_stall   = stall_raw & ~flush_on;
    alloc_valid_1 = alloc_req_1 & ~stall_raw & ~flush_on;
    alloc_valid_2 = alloc_req_2 & ~stall_raw & ~flush_on;
    n_grant       = {1'b0, alloc_valid_1} + {1'b0, alloc_valid_2};

    head_plus1  = wrap_add(head, 2'd1);
    alloc_tag_1 = fifo[head];
    // instr_2 takes the head slot only when instr_1 is not asking.
    alloc_tag_2 = (alloc_req_2 && !alloc_req_1) ? fifo[head] : fifo[head_plus1];

    push         = free_valid && (free_tag != '0) && (count != FULL) && !flush_on;
    overflow_hit = free_valid && (free_tag != '0) && (count == FULL) && !flush_on;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) fifo[i] <= TAG_W'(i + 1);
      head         <= '0;
      tail         <= '0;
      count        <= FULL;
      err_overflow <= 1'b0;
    end else if (flush_on) begin
      for (int i = 0; i < DEPTH; i++) fifo[i] <= TAG_W'(i + 1);
      head  <= '0;
      tail  <= '0;
      count <= FULL;
    end else begin
      head <= wrap_add(head, n_grant);
      if (push) begin
        fifo[tail] <= free_tag;
        tail       <= wrap_add(tail, 2'd1);
      end
      count <= count - (TAG_W+1)'(n_grant) + (TAG_W+1)'(push);
      if (overflow_hit) err_overflow <= 1'b1;
    end
  end

  assign free_count = count;

endmodule
